// File: rtl/romtest_rom.sv
// Loadable ROM: streamed fill in address order, then 1-cycle registered reads.
// Optional trailer checksum check enabled by ROMTEST_ROM_CHECKSUM_EN.
module romtest_rom #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  rom_ready,
  output logic                  load_err,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

`ifdef ROMTEST_ROM_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_LOAD,
    S_CHECK,
    S_SERVE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_LOAD,
    S_SERVE
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  accept;
  logic                  mem_we;

`ifdef ROMTEST_ROM_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;
  logic       err_q, err_d;
  logic [7:0] byte_lo;

  assign byte_lo  = 8'(load_data);
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  assign load_ready = (state_q != S_SERVE);
  assign rom_ready  = (state_q == S_SERVE);
  assign accept     = load_valid & load_ready;
  assign dout       = dout_q;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    mem_we  = 1'b0;
`ifdef ROMTEST_ROM_CHECKSUM_EN
    acc_d   = acc_q;
    err_d   = err_q;
`endif
    dout_d  = rom_ready ? mem[addr] : '0;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
`ifdef ROMTEST_ROM_CHECKSUM_EN
          acc_d  = acc_q + byte_lo;
          if (wptr_q == LAST) state_d = S_CHECK;
`else
          if (wptr_q == LAST) state_d = S_SERVE;
`endif
        end
      end
`ifdef ROMTEST_ROM_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (byte_lo != acc_q) err_d = 1'b1;
          state_d = S_SERVE;
        end
      end
`endif
      S_SERVE: state_d = S_SERVE;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      wptr_q  <= '0;
      dout_q  <= '0;
`ifdef ROMTEST_ROM_CHECKSUM_EN
      acc_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      dout_q  <= dout_d;
`ifdef ROMTEST_ROM_CHECKSUM_EN
      acc_q   <= acc_d;
      err_q   <= err_d;
`endif
    end
  end

  // Storage is not cleared by reset; a byte arriving with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[wptr_q[ADDR_WIDTH-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_romtest_rom.sv
// Scoreboard bench for romtest_rom: cycle model predicts outputs,
// expected read data is queued at drive time and popped one cycle later.
module tb_romtest_rom;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       rom_ready;
  logic       load_err;
  logic [7:0] addr;
  logic [7:0] dout;

  always #5 clk = ~clk;

  romtest_rom #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .rom_ready (rom_ready),
    .load_err  (load_err),
    .addr      (addr),
    .dout      (dout)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_mem[256];
  int         m_state = 0;  // 0 load, 1 check, 2 serve
  int         m_wptr  = 0;
  logic [7:0] m_acc   = 8'h00;
  bit         m_err   = 1'b0;

`ifdef ROMTEST_ROM_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int kind, input int i);
    case (kind)
      0:       return 8'(i) ^ 8'hA5;
      1:       return ~(8'(i) ^ 8'hA5);
      default: return 8'(i);
    endcase
  endfunction

  task automatic step();
    bit ok;
    ok = rst_n && (m_state != 2) && load_valid;
    exp_q.push_back((rst_n && m_state == 2) ? m_mem[addr] : 8'h00);
    if (!rst_n) begin
      m_state = 0;
      m_wptr  = 0;
      m_acc   = 8'h00;
      m_err   = 1'b0;
    end else if (ok) begin
      if (m_state == 0) begin
        m_mem[m_wptr] = load_data;
        m_acc += load_data;
        if (m_wptr == 255) m_state = CSUM ? 1 : 2;
        m_wptr++;
      end else begin
        if (load_data != m_acc) m_err = 1'b1;
        m_state = 2;
      end
    end
    @(posedge clk);
    #1;
    chk("dout", dout, exp_q.pop_front());
    chk("rom_ready", rom_ready, m_state == 2);
    chk("load_ready", load_ready, m_state != 2);
    chk("load_err", load_err, m_err);
  endtask

  task automatic do_reset(input int n);
    rst_n      = 1'b0;
    load_valid = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // trailer < 0 sends the model's own checksum in CHECK
  task automatic load_run(input int kind, input bit gaps,
                          input int trailer, input int stop_n);
    int cyc  = 0;
    int idle = 0;
    while (m_state != 2 && (stop_n < 0 || m_wptr < stop_n)
           && cyc < 3000) begin
      cyc++;
      if (m_state == 1)
        load_data = (trailer < 0) ? m_acc : 8'(trailer);
      else
        load_data = pat(kind, m_wptr);
      load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (gaps && m_wptr == 101 && idle < 5) begin
        load_valid = 1'b0;
        idle++;
      end
      if (!load_valid) load_data = 8'($urandom);
      step();
    end
    if (cyc >= 3000) chk("load_timeout", 0, 1);
    load_valid = 1'b0;
  endtask

  task automatic sweep(input bit junk);
    for (int i = 0; i < 256; i++) begin
      addr = 8'(i);
      if (junk) begin
        load_valid = 1'b1;
        load_data  = 8'($urandom);
      end
      step();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    addr       = 8'h00;

    do_reset(2);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_rom_ready", rom_ready, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_load_err", load_err, 0);

    // gapless load with addr parked at 0x10
    addr = 8'h10;
    load_run(0, 1'b0, -1, -1);
    step();
    chk("serve_mem16", dout, 8'hB5);
    sweep(1'b0);
    addr = 8'hFF;
    step();
    chk("wrap_hi", dout, 8'h5A);
    addr = 8'h00;
    step();
    chk("wrap_lo", dout, 8'hA5);

    // gappy load, junk load traffic while serving
    do_reset(1);
    load_run(0, 1'b1, -1, -1);
    sweep(1'b1);
    addr = 8'h64;
    step();
    chk("gap_mem100", dout, 8'hC1);

    // reset mid-load with a byte presented, then inverted reload
    do_reset(1);
    addr = 8'h33;
    load_run(1, 1'b0, -1, 128);
    rst_n      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    step();
    rst_n = 1'b1;
    chk("midrst_ready", load_ready, 1);
    load_run(1, 1'b0, -1, -1);
    addr = 8'h00;
    step();
    chk("reload_mem0", dout, 8'h5A);
    sweep(1'b0);

`ifdef ROMTEST_ROM_CHECKSUM_EN
    do_reset(1);
    load_run(2, 1'b0, 8'h80, -1);
    chk("csum_good_err", load_err, 0);
    chk("csum_good_rdy", rom_ready, 1);
    do_reset(1);
    load_run(2, 1'b0, 8'h81, -1);
    chk("csum_bad_err", load_err, 1);
    chk("csum_bad_rdy", rom_ready, 1);
    repeat (5) step();
    chk("csum_sticky", load_err, 1);
    do_reset(1);
    chk("csum_clr", load_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
